// File: rtl/fb_swap_pkg.sv
// Shared types for the framebuffer swap controller.
// Buffer count follows FB_TRIPLE_BUFFER_EN (3 when defined, else 2).
package fb_swap_pkg;

    typedef logic [1:0] fb_idx_t;

    typedef enum logic {
        RENDER  = 1'b0,
        PENDING = 1'b1
    } fb_state_t;

`ifdef FB_TRIPLE_BUFFER_EN
    localparam int FB_NUM_BUFS = 3;
`else
    localparam int FB_NUM_BUFS = 2;
`endif

endpackage

// File: rtl/fb_addr_lut.sv
// Buffer index to DRAM byte address, from elaborated constants.
// Indices beyond the configured buffer count fall back to buffer 0.
module fb_addr_lut
    import fb_swap_pkg::*;
#(
    parameter logic [31:0] FB_BASE   = 32'h0010_0000,
    parameter logic [31:0] FB_STRIDE = 32'h000E_A600
) (
    input  fb_idx_t     i_idx,
    output logic [31:0] o_addr
);

    localparam logic [31:0] A0 = FB_BASE;
    localparam logic [31:0] A1 = FB_BASE + FB_STRIDE;
    localparam logic [31:0] A2 = FB_BASE + (FB_STRIDE << 1);

    // constant lookup, no multiplier
    always_comb begin
        o_addr = A0;
        unique case (i_idx)
            2'd1:    o_addr = A1;
            2'd2:    o_addr = (FB_NUM_BUFS > 2) ? A2 : A0;
            default: o_addr = A0;
        endcase
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Framebuffer swap controller: swaps commit only on frame-load pulses.
// Define FB_TRIPLE_BUFFER_EN for triple buffering (renderer never stalls).
module fb_swap_ctrl
    import fb_swap_pkg::*;
#(
    parameter logic [31:0] FB_BASE   = 32'h0010_0000,
    parameter logic [31:0] FB_STRIDE = 32'h000E_A600,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_new,
    input  logic             render_done,
    output logic [31:0]      fb_addr,
    output logic [31:0]      back_addr,
    output logic             back_valid,
    output logic             swap_done,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count
);

    fb_state_t        r_state;
    fb_idx_t          r_front;
    fb_idx_t          r_back;
    fb_idx_t          r_pend;
    logic [31:0]      r_fb_addr;
    logic [31:0]      r_back_addr;
    logic             r_back_valid;
    logic             r_swap_done;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    fb_state_t        w_state;
    fb_idx_t          w_front;
    fb_idx_t          w_back;
    fb_idx_t          w_pend;
    fb_idx_t          w_fb_idx;
    logic             w_swap;
    logic             w_drop;
    logic [31:0]      w_fb_addr;
    logic [31:0]      w_back_addr;

`ifdef FB_TRIPLE_BUFFER_EN
    fb_idx_t          r_spare;
    fb_idx_t          w_spare;
`endif

    // start_new acts on pre-cycle state, then render_done on the result
    always_comb begin
        w_swap  = start_new && (r_state == PENDING);
        w_state = r_state;
        w_front = r_front;
        w_back  = r_back;
        w_pend  = r_pend;
        w_drop  = 1'b0;
`ifdef FB_TRIPLE_BUFFER_EN
        w_spare = r_spare;
`endif
        if (w_swap) begin
            w_front = r_pend;
            w_state = RENDER;
`ifdef FB_TRIPLE_BUFFER_EN
            w_spare = r_front;
`else
            w_back  = r_front;
`endif
        end
        if (render_done) begin
`ifdef FB_TRIPLE_BUFFER_EN
            w_pend = w_back;
            if (w_state == PENDING) begin
                w_back = r_pend;
                w_drop = 1'b1;
            end else begin
                w_back = w_spare;
            end
            w_state = PENDING;
`else
            if (w_state == PENDING) begin
                w_drop = 1'b1;
            end else begin
                w_pend  = w_back;
                w_state = PENDING;
            end
`endif
        end
        w_fb_idx = (w_state == PENDING) ? w_pend : w_front;
    end

    fb_addr_lut #(
        .FB_BASE   (FB_BASE),
        .FB_STRIDE (FB_STRIDE)
    ) u_fb_lut (
        .i_idx  (w_fb_idx),
        .o_addr (w_fb_addr)
    );

    fb_addr_lut #(
        .FB_BASE   (FB_BASE),
        .FB_STRIDE (FB_STRIDE)
    ) u_back_lut (
        .i_idx  (w_back),
        .o_addr (w_back_addr)
    );

    // swap FSM with registered outputs and wrapping counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RENDER;
            r_front      <= 2'd0;
            r_back       <= 2'd1;
            r_pend       <= 2'd0;
            r_fb_addr    <= FB_BASE;
            r_back_addr  <= FB_BASE + FB_STRIDE;
            r_back_valid <= 1'b1;
            r_swap_done  <= 1'b0;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
`ifdef FB_TRIPLE_BUFFER_EN
            r_spare      <= 2'd2;
`endif
        end else begin
            r_state      <= w_state;
            r_front      <= w_front;
            r_back       <= w_back;
            r_pend       <= w_pend;
            r_fb_addr    <= w_fb_addr;
            r_back_addr  <= w_back_addr;
`ifdef FB_TRIPLE_BUFFER_EN
            r_spare      <= w_spare;
            r_back_valid <= 1'b1;
`else
            r_back_valid <= (w_state == RENDER);
`endif
            r_swap_done  <= w_swap;
            r_frame_cnt  <= r_frame_cnt + {{(CNT_W-1){1'b0}}, start_new};
            r_drop_cnt   <= r_drop_cnt + {{(CNT_W-1){1'b0}}, w_drop};
        end
    end

    assign fb_addr     = r_fb_addr;
    assign back_addr   = r_back_addr;
    assign back_valid  = r_back_valid;
    assign swap_done   = r_swap_done;
    assign frame_count = r_frame_cnt;
    assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Self-checking bench for fb_swap_ctrl: directed table, corner
// sequences and random pulses against a buffer-ownership model.
module tb_fb_swap_ctrl;

    localparam logic [31:0] FB_BASE   = 32'h0010_0000;
    localparam logic [31:0] FB_STRIDE = 32'h000E_A600;
    localparam int          CNT_W     = 16;

    localparam logic [31:0] A0 = 32'h0010_0000;
    localparam logic [31:0] A1 = 32'h001E_A600;
    localparam logic [31:0] A2 = 32'h002D_4C00;

    logic             clk;
    logic             rst;
    logic             start_new;
    logic             render_done;
    logic [31:0]      fb_addr;
    logic [31:0]      back_addr;
    logic             back_valid;
    logic             swap_done;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] drop_count;

    fb_swap_ctrl #(
        .FB_BASE   (FB_BASE),
        .FB_STRIDE (FB_STRIDE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_new   (start_new),
        .render_done (render_done),
        .fb_addr     (fb_addr),
        .back_addr   (back_addr),
        .back_valid  (back_valid),
        .swap_done   (swap_done),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: who owns which buffer, not how the RTL encodes it
    int               m_front;
    int               m_back;
    int               m_pend;
    bit               m_pv;
    bit               m_sd;
    logic [CNT_W-1:0] m_frames;
    logic [CNT_W-1:0] m_drops;

    function automatic logic [31:0] addr_of(int i);
        return FB_BASE + FB_STRIDE * 32'(i);
    endfunction

    task automatic model_reset();
        m_front  = 0;
        m_back   = 1;
        m_pend   = 0;
        m_pv     = 0;
        m_sd     = 0;
        m_frames = '0;
        m_drops  = '0;
    endtask

    task automatic model_step(input bit sn, input bit rd);
        m_sd = 0;
        if (sn) begin
            m_frames = m_frames + 1'b1;
            if (m_pv) begin
                m_front = m_pend;
                m_pv    = 0;
                m_sd    = 1;
`ifndef FB_TRIPLE_BUFFER_EN
                m_back  = 1 - m_front;
`endif
            end
        end
        if (rd) begin
`ifdef FB_TRIPLE_BUFFER_EN
            if (m_pv) m_drops = m_drops + 1'b1;
            m_pend = m_back;
            m_pv   = 1;
            m_back = 3 - m_front - m_pend;
`else
            if (m_pv) begin
                m_drops = m_drops + 1'b1;
            end else begin
                m_pend = m_back;
                m_pv   = 1;
            end
`endif
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h @%0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic chk_model();
        logic [31:0] efb;
        bit          ebv;
        efb = addr_of(m_pv ? m_pend : m_front);
`ifdef FB_TRIPLE_BUFFER_EN
        ebv = 1'b1;
`else
        ebv = !m_pv;
`endif
        chk("fb_addr", fb_addr, efb);
        chk("back_addr", back_addr, addr_of(m_back));
        chk("back_valid", 32'(back_valid), 32'(ebv));
        chk("swap_done", 32'(swap_done), 32'(m_sd));
        chk("frame_count", 32'(frame_count), 32'(m_frames));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    task automatic step(input bit sn, input bit rd);
        start_new   = sn;
        render_done = rd;
        @(posedge clk);
        #1;
        start_new   = 1'b0;
        render_done = 1'b0;
        model_step(sn, rd);
        chk_model();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start_new   = 1'b0;
        render_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          sn;
        bit          rd;
        logic [31:0] fb;
        logic [31:0] ba;
        bit          bv;
        bit          sd;
    } vec_t;

    vec_t tbl[8];

    initial begin
`ifdef FB_TRIPLE_BUFFER_EN
        tbl[0] = '{1, 0, A0, A1, 1, 0};
        tbl[1] = '{0, 1, A1, A2, 1, 0};
        tbl[2] = '{0, 1, A2, A1, 1, 0};
        tbl[3] = '{1, 0, A2, A1, 1, 1};
        tbl[4] = '{0, 0, A2, A1, 1, 0};
        tbl[5] = '{1, 1, A1, A0, 1, 0};
        tbl[6] = '{1, 1, A0, A2, 1, 1};
        tbl[7] = '{1, 0, A0, A2, 1, 1};
`else
        tbl[0] = '{1, 0, A0, A1, 1, 0};
        tbl[1] = '{0, 1, A1, A1, 0, 0};
        tbl[2] = '{0, 1, A1, A1, 0, 0};
        tbl[3] = '{1, 0, A1, A0, 1, 1};
        tbl[4] = '{0, 0, A1, A0, 1, 0};
        tbl[5] = '{1, 1, A0, A0, 0, 0};
        tbl[6] = '{1, 1, A1, A1, 0, 1};
        tbl[7] = '{1, 0, A1, A0, 1, 1};
`endif

        do_reset();
        chk("rst fb_addr", fb_addr, A0);
        chk("rst back_addr", back_addr, A1);
        chk("rst back_valid", 32'(back_valid), 32'd1);
        chk("rst swap_done", 32'(swap_done), 32'd0);
        chk("rst frame_count", 32'(frame_count), 32'd0);
        chk("rst drop_count", 32'(drop_count), 32'd0);

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].sn, tbl[i].rd);
            chk($sformatf("tbl%0d fb", i), fb_addr, tbl[i].fb);
            chk($sformatf("tbl%0d ba", i), back_addr, tbl[i].ba);
            chk($sformatf("tbl%0d bv", i), 32'(back_valid), 32'(tbl[i].bv));
            chk($sformatf("tbl%0d sd", i), 32'(swap_done), 32'(tbl[i].sd));
        end
        chk("tbl drops", 32'(drop_count), 32'd1);
        chk("tbl frames", 32'(frame_count), 32'd5);

        // three frame loads, nothing rendered
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("idle fb_addr", fb_addr, A0);
            chk("idle no swap", 32'(swap_done), 32'd0);
        end
        chk("idle frames", 32'(frame_count), 32'd3);

        // render early, frame load much later
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("late fb_addr", fb_addr, A1);
        for (int i = 0; i < 39; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("late swap", 32'(swap_done), 32'd1);
`ifndef FB_TRIPLE_BUFFER_EN
        chk("late back_addr", back_addr, A0);
        chk("late back_valid", 32'(back_valid), 32'd1);
`endif

        // same-cycle pulses straight out of reset
        do_reset();
        step(1'b1, 1'b1);
        chk("same no swap", 32'(swap_done), 32'd0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("same next swap", 32'(swap_done), 32'd1);

        // asynchronous reset while a render is pending
        do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst fb_addr", fb_addr, A0);
        chk("arst back_addr", back_addr, A1);
        chk("arst back_valid", 32'(back_valid), 32'd1);
        chk("arst drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_model();

        // random pulse traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Framebuffer swap controller on the system clock, sequencing which DRAM framebuffer the VGA scan-out path reads and which one the renderer draws into. It sits between the GPU render engine and the VGA driver. It consumes the driver's once-per-frame `start_new` pulse and the renderer's `render_done` pulse, and drives the driver's framebuffer base address. All swaps commit only at frame-load boundaries, so scan-out never tears.

## Interface
Parameters:
- `FB_BASE`, default 32'h0010_0000: byte address of buffer 0.
- `FB_STRIDE`, default 32'h000E_A600: byte size of one buffer (800×600×2 bytes).
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start_new`, in, 1: one-cycle pulse from the VGA driver; the frame load from `fb_addr` begins in this cycle.
- `render_done`, in, 1: one-cycle pulse from the renderer; rendering into `back_addr` is complete.
- `fb_addr`, out, 32: base address of the next frame load, to the VGA driver.
- `back_addr`, out, 32: buffer the renderer may write.
- `back_valid`, out, 1: renderer may write `back_addr`; the renderer stalls while this is 0.
- `swap_done`, out, 1: one-cycle pulse, a swap committed.
- `frame_count`, out, CNT_W: count of `start_new` pulses.
- `drop_count`, out, CNT_W: count of rendered frames discarded or ignored.

## Operation
- Buffer index is 2 bits. Buffer address is `FB_BASE + idx*FB_STRIDE`, computed modulo 2^32 and held as elaborated constants. There is no runtime multiply.
- Registered state:
  - `front` idx: the buffer being scanned out.
  - `back` idx: the buffer being rendered.
  - `pend` idx plus `pend_v` flag: a rendered buffer awaiting display.
  - `spare` idx, triple-buffer mode only.
- `fb_addr` is addr(`pend`) when `pend_v` is 1, otherwise addr(`front`). It is registered, so it is stable whenever `start_new` is sampled.
- State machine, double-buffer mode:
  - RENDER to PENDING on `render_done`: `pend` <= `back`, `pend_v` <= 1, `back_valid` <= 0.
  - PENDING to RENDER on `start_new`: `front` <= `pend`, `back` <= old `front`, `pend_v` <= 0, `back_valid` <= 1, `swap_done` pulses.
  - `render_done` while in PENDING is ignored and increments `drop_count`.
- Triple-buffer mode: `back_valid` stays 1 at all times.
  - `render_done` with `pend_v` = 0: `pend` <= `back`, `back` <= `spare`.
  - `render_done` with `pend_v` = 1: `pend` <= `back`, `back` <= old `pend`, `drop_count` increments. The newest render wins.
  - `start_new` with `pend_v` = 1: `front` <= `pend`, `spare` <= old `front`, `swap_done` pulses.
- `start_new` with `pend_v` = 0 leaves `front` unchanged; no swap occurs.
- `frame_count` increments on every `start_new`. Both counters wrap at 2^CNT_W.
- `render_done` and `start_new` in the same cycle: `start_new` is evaluated against the pre-cycle `pend_v`, then `render_done` is applied against the post-`start_new` state.
  - If `pend_v` was 0, no swap occurs this frame. The new pending buffer is shown at the next `start_new`.
  - If `pend_v` was 1, the swap commits and the new render becomes pending. In double-buffer mode, `back_valid` returns to 0.

## Timing
- Reset values:
  - `front`=0, `back`=1, `spare`=2, `pend_v`=0.
  - `fb_addr`=`FB_BASE`, `back_addr`=`FB_BASE+FB_STRIDE`, `back_valid`=1.
  - `swap_done`=0, both counters 0.
- All outputs are registered. Every update appears in the cycle after the triggering pulse.
- `fb_addr` updates 1 cycle after `render_done`, so it must lead the next `start_new` by at least 1 cycle.
- `swap_done`, `back_addr` and `back_valid` update 1 cycle after `start_new`.
- Reset asserted mid-frame: all state returns to reset values immediately. The pending render is lost and is not counted as a drop.

## Configuration
- `FB_TRIPLE_BUFFER_EN` defined: three buffers, `spare` register present, renderer never stalls, newest-render-wins dropping.
- `FB_TRIPLE_BUFFER_EN` undefined: two buffers, RENDER/PENDING stall behaviour. `drop_count` counts protocol violations (`render_done` while `back_valid` is 0).

## Structure
- Package `fb_swap_pkg` contains:
  - `fb_idx_t` (2-bit buffer index).
  - State enum {RENDER, PENDING}.
  - `FB_NUM_BUFS` (2 or 3, selected by the macro).
- Sub-module `fb_addr_lut` maps index to address from `FB_BASE`/`FB_STRIDE` constants.
- The module has two instances of `fb_addr_lut`: one for `fb_addr`, one for `back_addr`.

## Test plan
Buffer addresses at default parameters: buffer 0 = 0x0010_0000, buffer 1 = 0x001E_A600, buffer 2 = 0x002D_4C00.
- Reset, then 3 `start_new` pulses with no `render_done`: `fb_addr`=0x0010_0000 throughout, `frame_count`=3, no `swap_done`.
- Double mode, `render_done` at cycle 10, `start_new` at cycle 50:
  - cycle 11: `fb_addr`=0x001E_A600, `back_valid`=0.
  - cycle 51: `swap_done`=1, `back_addr`=0x0010_0000, `back_valid`=1.
- Double mode, 2 `render_done` pulses before a `start_new`: `drop_count`=1, and the single swap shows 0x001E_A600.
- Triple mode, 2 `render_done` pulses before a `start_new`: `back_valid` stays 1, `drop_count`=1, and `fb_addr`=0x002D_4C00 at the `start_new`.
- Same-cycle `render_done` and `start_new` from reset: no `swap_done` that frame; `swap_done` at the following `start_new`.
- `rst` asserted while PENDING: outputs return to reset values asynchronously, `drop_count`=0.
